rst_seq: RTL and testbench
==========================

RST_SEQ -- requirements
Module: rst_seq

Interface
REQ-001 Parameter ADDR_W, default 10: frame-buffer address width.
REQ-002 Parameter DEPTH, default 1024: pixels to clear; range 1..2^ADDR_W, need not be a power of two.
REQ-003 Parameter PIX_W, default 3: pixel data width.
REQ-004 Parameter CLR_COLOR, default 0: value written to every pixel; width PIX_W.
REQ-005 Parameter SETTLE_CYC, default 16: cycles to wait before clearing starts; minimum 1.
REQ-006 clk  in  1  single system clock; all logic on its rising edge.
REQ-007 rst  in  1  asynchronous, active-low reset.
REQ-008 state  in  3  mode-FSM state, using the `st_state.v` encodings (`RST, `SLEEP, `LIGHT, `DRAW, `WRITE, `ERASE, `COLOR, `STOP).
REQ-009 wr_ready  in  1  frame buffer accepts the write this cycle.
REQ-010 wr_en  out  1  write request to the frame buffer.
REQ-011 wr_addr  out  ADDR_W  write address.
REQ-012 wr_data  out  PIX_W  write data.
REQ-013 busy  out  1  high while in SETTLE or CLEAR.
REQ-014 rst_ok  out  1  reset-complete response to the mode FSM.

Function
REQ-015 The block SHALL implement a 4-state FSM: IDLE, SETTLE, CLEAR, DONE. All outputs SHALL be registered or decoded Moore from the FSM registers.
REQ-016 IDLE: on a clock edge where state==`RST, the block SHALL go to SETTLE and clear the settle counter to 0. Any other state value SHALL keep it in IDLE.
REQ-017 SETTLE: the block SHALL stay exactly SETTLE_CYC cycles. It SHALL then go to CLEAR with wr_addr=0.
REQ-018 CLEAR: the block SHALL hold wr_en=1 and wr_data=CLR_COLOR.
- A write is accepted on an edge where wr_en and wr_ready are both 1.
- On acceptance, wr_addr SHALL increment by 1.
- While wr_ready=0, wr_addr and wr_data SHALL hold stable.
REQ-019 When the write at wr_addr==DEPTH-1 is accepted, the block SHALL go to DONE. Exactly DEPTH writes SHALL be performed, to addresses 0..DEPTH-1, each written once, with no wrap-around.
REQ-020 DONE: rst_ok SHALL be 1 and wr_en SHALL be 0. The block SHALL stay in DONE while state==`RST. It SHALL go to IDLE, dropping rst_ok, on the first edge where state!=`RST.
REQ-021 rst_ok SHALL be 1 only in DONE. busy SHALL be 1 only in SETTLE and CLEAR. wr_en SHALL be 1 only in CLEAR.
REQ-022 Latency: with wr_ready held at 1, rst_ok SHALL rise SETTLE_CYC+DEPTH edges after the edge that sampled state==`RST in IDLE. Each wr_ready=0 cycle SHALL add exactly one cycle.
REQ-023 Abort: if state!=`RST on any edge in SETTLE or CLEAR, the block SHALL go to IDLE on that edge.
- wr_en SHALL be 0 from the next cycle.
- wr_addr SHALL reset to 0.
- rst_ok SHALL NOT assert.
REQ-024 Restart: after an abort or a completed run, a new state==`RST SHALL start a full sequence from SETTLE and address 0.
REQ-025 The counter widths SHALL be ceil(log2(SETTLE_CYC+1)) for the settle counter and ADDR_W for the address counter. Counters SHALL NOT overflow for any legal parameter value.

Reset
REQ-026 While rst=0, the FSM SHALL be IDLE and the outputs SHALL be: wr_en=0, wr_addr=0, wr_data=CLR_COLOR, busy=0, rst_ok=0. This SHALL take effect asynchronously.
REQ-027 Release of rst SHALL be sampled synchronously. If state==`RST on the first edge after release, the sequence SHALL start on that edge.
REQ-028 Assertion of rst mid-CLEAR SHALL immediately force wr_en=0, whatever the value of wr_ready.

Verification
REQ-029 Nominal run:
- Stimulus: SETTLE_CYC=4, DEPTH=16, wr_ready=1, state=`RST held.
- Response: busy rises next edge; wr_addr runs 0..15 with one write per cycle; rst_ok rises 20 edges after start; exactly 16 writes, all CLR_COLOR.
REQ-030 Backpressure:
- Stimulus: as REQ-029, but wr_ready=0 on every third CLEAR cycle.
- Response: address and data held during stalls; rst_ok delayed by the stall count; no address skipped or repeated.
REQ-031 Handoff:
- Stimulus: in DONE, state changes to `SLEEP.
- Response: rst_ok=0 and FSM IDLE one edge later; no further writes.
REQ-032 Abort:
- Stimulus: state changes to `STOP at wr_addr=7 during CLEAR.
- Response: wr_en=0 next cycle; rst_ok never asserts; a later `RST restarts from SETTLE with wr_addr=0.
REQ-033 Async reset:
- Stimulus: rst driven low mid-SETTLE and mid-CLEAR, asynchronously to clk.
- Response: all outputs at reset values before the next edge.
- Stimulus: release rst with state=`RST.
- Response: a full sequence follows.
REQ-034 Odd depth:
- Stimulus: DEPTH=5, ADDR_W=3.
- Response: writes to addresses 0..4 only; DONE reached; no write to addresses 5..7.

Source files
------------

// File: rtl/rst_seq.sv
// rst_seq: frame-buffer clear sequencer driven by the mode FSM's RST state.
// On RST it waits SETTLE_CYC cycles, writes CLR_COLOR to addresses
// 0..DEPTH-1 with wr_ready backpressure, then reports rst_ok until the mode
// FSM leaves RST. Leaving RST early aborts back to IDLE.
module rst_seq #(
    parameter int                ADDR_W     = 10,
    parameter int                DEPTH      = 1024,
    parameter int                PIX_W      = 3,
    parameter logic [PIX_W-1:0]  CLR_COLOR  = '0,
    parameter int                SETTLE_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [2:0]        state,
    input  logic              wr_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [PIX_W-1:0]  wr_data,
    output logic              busy,
    output logic              rst_ok
);

    // Mode-FSM encoding of RST, matching st_state.v.
    localparam logic [2:0] ST_RST = 3'd0;

    // Settle counter only has to reach SETTLE_CYC-1; sized to hold SETTLE_CYC.
    localparam int SCW = $clog2(SETTLE_CYC + 1);
    localparam logic [SCW-1:0]    SETTLE_LAST = SCW'(SETTLE_CYC - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST   = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETTLE,
        S_CLEAR,
        S_DONE
    } fsm_t;

    fsm_t              r_fsm,  w_fsm_nxt;
    logic [SCW-1:0]    r_cnt,  w_cnt_nxt;
    logic [ADDR_W-1:0] r_addr, w_addr_nxt;
    logic              w_in_rst;

    assign w_in_rst = (state == ST_RST);

    // State and counter registers; async reset forces IDLE (and wr_en low).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fsm  <= S_IDLE;
            r_cnt  <= '0;
            r_addr <= '0;
        end else begin
            r_fsm  <= w_fsm_nxt;
            r_cnt  <= w_cnt_nxt;
            r_addr <= w_addr_nxt;
        end
    end

    // Next-state and counter updates; any exit to IDLE parks the address at 0.
    always_comb begin
        w_fsm_nxt  = r_fsm;
        w_cnt_nxt  = r_cnt;
        w_addr_nxt = r_addr;
        case (r_fsm)
            S_IDLE: begin
                if (w_in_rst) begin
                    w_fsm_nxt  = S_SETTLE;
                    w_cnt_nxt  = '0;
                    w_addr_nxt = '0;
                end
            end
            S_SETTLE: begin
                if (!w_in_rst) begin
                    w_fsm_nxt  = S_IDLE;
                    w_cnt_nxt  = '0;
                    w_addr_nxt = '0;
                end else if (r_cnt == SETTLE_LAST) begin
                    w_fsm_nxt  = S_CLEAR;
                    w_addr_nxt = '0;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_CLEAR: begin
                if (!w_in_rst) begin
                    w_fsm_nxt  = S_IDLE;
                    w_addr_nxt = '0;
                end else if (wr_ready) begin
                    // Last address is never incremented, so no wrap even
                    // when DEPTH == 2**ADDR_W.
                    if (r_addr == ADDR_LAST) begin
                        w_fsm_nxt  = S_DONE;
                        w_addr_nxt = '0;
                    end else begin
                        w_addr_nxt = r_addr + 1'b1;
                    end
                end
            end
            S_DONE: begin
                if (!w_in_rst) begin
                    w_fsm_nxt = S_IDLE;
                end
            end
            default: begin
                w_fsm_nxt  = S_IDLE;
                w_addr_nxt = '0;
            end
        endcase
    end

    // Moore outputs decoded from the state register.
    assign wr_en   = (r_fsm == S_CLEAR);
    assign busy    = (r_fsm == S_SETTLE) || (r_fsm == S_CLEAR);
    assign rst_ok  = (r_fsm == S_DONE);
    assign wr_addr = r_addr;
    assign wr_data = CLR_COLOR;

endmodule

// File: tb/tb_rst_seq.sv
// Directed bench for rst_seq: a 16-pixel instance covers nominal, handoff,
// backpressure, abort and async reset; a 5-pixel instance covers odd depth.
module tb_rst_seq;

    localparam logic [2:0] ST_RST   = 3'd0;
    localparam logic [2:0] ST_SLEEP = 3'd1;
    localparam logic [2:0] ST_STOP  = 3'd7;
    localparam logic [2:0] CLR      = 3'd5;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] state = ST_SLEEP;
    logic       wr_ready = 1'b1;
    logic       wr_en, busy, rst_ok;
    logic [9:0] wr_addr;
    logic [2:0] wr_data;

    logic [2:0] state_b = ST_SLEEP;
    logic       ready_b = 1'b1;
    logic       wr_en_b, busy_b, rst_ok_b;
    logic [2:0] wr_addr_b;
    logic [2:0] wr_data_b;

    int checks = 0;
    int errors = 0;
    int wcnt_b [8];

    always #5 clk = ~clk;

    rst_seq #(.ADDR_W(10), .DEPTH(16), .PIX_W(3), .CLR_COLOR(CLR), .SETTLE_CYC(4)) u_dut (
        .clk(clk), .rst(rst), .state(state), .wr_ready(wr_ready),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .rst_ok(rst_ok)
    );

    rst_seq #(.ADDR_W(3), .DEPTH(5), .PIX_W(3), .CLR_COLOR(CLR), .SETTLE_CYC(4)) u_odd (
        .clk(clk), .rst(rst), .state(state_b), .wr_ready(ready_b),
        .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b),
        .busy(busy_b), .rst_ok(rst_ok_b)
    );

    // Log accepted writes of the odd-depth instance per address.
    always @(posedge clk) begin
        if (wr_en_b && ready_b) wcnt_b[wr_addr_b] <= wcnt_b[wr_addr_b] + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #3;
        checks++; if (wr_en !== 1'b0)   begin errors++; $display("FAIL reset_wr_en got %b exp 0", wr_en); end
        checks++; if (wr_addr !== 10'd0) begin errors++; $display("FAIL reset_wr_addr got %0d exp 0", wr_addr); end
        checks++; if (wr_data !== CLR)   begin errors++; $display("FAIL reset_wr_data got %0d exp %0d", wr_data, CLR); end
        checks++; if (busy !== 1'b0)     begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
        checks++; if (rst_ok !== 1'b0)   begin errors++; $display("FAIL reset_rst_ok got %b exp 0", rst_ok); end
        tick();
        rst = 1'b1;
        tick(); tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_no_rst busy got %b exp 0", busy); end
    endtask

    // Start from IDLE: sample RST, then 4 settle cycles; ends in CLEAR at addr 0.
    task automatic run_settle(input string tag);
        state = ST_RST;
        tick();
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (busy !== 1'b1 || wr_en !== 1'b0 || rst_ok !== 1'b0) begin
                errors++; $display("FAIL %s_settle%0d busy/wr_en/rst_ok got %b%b%b exp 100", tag, i, busy, wr_en, rst_ok);
            end
            tick();
        end
    endtask

    // From CLEAR at addr 0 with wr_ready=1: 16 writes then DONE.
    task automatic run_clear(input string tag);
        for (int k = 0; k < 16; k++) begin
            checks++;
            if (wr_en !== 1'b1 || wr_addr !== 10'(k) || wr_data !== CLR || rst_ok !== 1'b0) begin
                errors++; $display("FAIL %s_clear%0d en=%b addr=%0d data=%0d ok=%b exp en=1 addr=%0d data=%0d ok=0",
                                   tag, k, wr_en, wr_addr, wr_data, rst_ok, k, CLR);
            end
            tick();
        end
        checks++;
        if (rst_ok !== 1'b1 || wr_en !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL %s_done ok/en/busy got %b%b%b exp 100", tag, rst_ok, wr_en, busy);
        end
    endtask

    task automatic test_nominal();
        wr_ready = 1'b1;
        run_settle("nom");
        run_clear("nom");
    endtask

    task automatic test_handoff();
        tick(); tick();
        checks++; if (rst_ok !== 1'b1) begin errors++; $display("FAIL handoff_hold rst_ok got %b exp 1", rst_ok); end
        state = ST_SLEEP;
        tick();
        checks++; if (rst_ok !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL handoff_idle ok/busy got %b%b exp 00", rst_ok, busy); end
        tick();
        checks++; if (wr_en !== 1'b0) begin errors++; $display("FAIL handoff_nowrite wr_en got %b exp 0", wr_en); end
    endtask

    task automatic test_backpressure();
        int exp_addr;
        int c;
        run_settle("bp");
        exp_addr = 0;
        c = 0;
        while (exp_addr < 16 && c < 64) begin
            wr_ready = (c % 3 == 2) ? 1'b0 : 1'b1;
            checks++;
            if (wr_en !== 1'b1 || wr_addr !== 10'(exp_addr) || wr_data !== CLR || rst_ok !== 1'b0) begin
                errors++; $display("FAIL bp_cyc%0d en=%b addr=%0d data=%0d ok=%b exp en=1 addr=%0d ok=0",
                                   c, wr_en, wr_addr, wr_data, rst_ok, exp_addr);
            end
            tick();
            if (wr_ready) exp_addr++;
            c++;
        end
        wr_ready = 1'b1;
        checks++; if (rst_ok !== 1'b1) begin errors++; $display("FAIL bp_done rst_ok got %b exp 1", rst_ok); end
        state = ST_SLEEP;
        tick();
    endtask

    task automatic test_abort();
        run_settle("ab");
        for (int k = 0; k < 7; k++) tick();
        checks++; if (wr_addr !== 10'd7 || wr_en !== 1'b1) begin errors++; $display("FAIL abort_pre addr=%0d en=%b exp 7 1", wr_addr, wr_en); end
        state = ST_STOP;
        tick();
        checks++;
        if (wr_en !== 1'b0 || wr_addr !== 10'd0 || busy !== 1'b0 || rst_ok !== 1'b0) begin
            errors++; $display("FAIL abort_idle en=%b addr=%0d busy=%b ok=%b exp 0 0 0 0", wr_en, wr_addr, busy, rst_ok);
        end
        tick(); tick();
        checks++; if (rst_ok !== 1'b0 || wr_en !== 1'b0) begin errors++; $display("FAIL abort_stay ok/en got %b%b exp 00", rst_ok, wr_en); end
        run_settle("abre");
        checks++; if (wr_en !== 1'b1 || wr_addr !== 10'd0) begin errors++; $display("FAIL abort_restart en=%b addr=%0d exp 1 0", wr_en, wr_addr); end
        state = ST_SLEEP;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_clear_exit busy got %b exp 0", busy); end
    endtask

    task automatic test_async_reset();
        state = ST_RST;
        tick();
        #2 rst = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0 || wr_en !== 1'b0 || wr_addr !== 10'd0 || rst_ok !== 1'b0) begin
            errors++; $display("FAIL async_settle busy=%b en=%b addr=%0d ok=%b exp all 0", busy, wr_en, wr_addr, rst_ok);
        end
        #2 rst = 1'b1;
        tick();
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL async_release_start busy got %b exp 1", busy); end
        for (int i = 0; i < 3; i++) tick();
        tick();
        tick(); tick(); tick();
        checks++; if (wr_en !== 1'b1 || wr_addr !== 10'd3) begin errors++; $display("FAIL async_midclear_pre en=%b addr=%0d exp 1 3", wr_en, wr_addr); end
        wr_ready = 1'b0;
        #2 rst = 1'b0;
        #1;
        checks++;
        if (wr_en !== 1'b0 || busy !== 1'b0 || wr_addr !== 10'd0 || wr_data !== CLR) begin
            errors++; $display("FAIL async_clear en=%b busy=%b addr=%0d data=%0d exp 0 0 0 %0d", wr_en, busy, wr_addr, wr_data, CLR);
        end
        wr_ready = 1'b1;
        #2 rst = 1'b1;
        tick();
        for (int i = 0; i < 3; i++) tick();
        tick();
        run_clear("asyn");
        state = ST_SLEEP;
        tick();
    endtask

    task automatic test_odd_depth();
        for (int a = 0; a < 8; a++) wcnt_b[a] = 0;
        ready_b = 1'b1;
        state_b = ST_RST;
        tick();
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 5; i++) begin
            checks++; if (rst_ok_b !== 1'b0) begin errors++; $display("FAIL odd_early_ok cyc%0d got %b exp 0", i, rst_ok_b); end
            tick();
        end
        checks++; if (rst_ok_b !== 1'b1 || wr_en_b !== 1'b0) begin errors++; $display("FAIL odd_done ok/en got %b%b exp 10", rst_ok_b, wr_en_b); end
        tick(); tick();
        for (int a = 0; a < 8; a++) begin
            checks++;
            if (wcnt_b[a] !== ((a < 5) ? 1 : 0)) begin
                errors++; $display("FAIL odd_writes addr%0d got %0d exp %0d", a, wcnt_b[a], (a < 5) ? 1 : 0);
            end
        end
        state_b = ST_SLEEP;
        tick();
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_handoff();
        test_backpressure();
        test_abort();
        test_async_reset();
        test_odd_depth();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
